// File: rtl/gossamer_stimulus.sv
// Pattern driver and response checker for the guitarist bundle.
// Optional build macro GOSSAMER_LFSR_EN selects an x^4+x^3+1 LFSR pattern source instead of a counter.
module gossamer_stimulus #(
  parameter int NUM_PATTERNS = 16,
  parameter int RESP_LAT     = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             stop,
  output logic [1:0]       gossamer,
  output logic             disconnection,
  output logic             two_guitars,
  input  logic             nothing_of_note,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [7:0]       pattern_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [3:0]          gen_q;
  logic [3:0]          gen_d;
  logic [3:0]          init_pat;
  logic [3:0]          bundle_q;
  logic [2:0]          drain_q;
  logic [7:0]          idx_q;
  logic                busy_q;
  logic                done_q;
  logic                last_pat;
  logic                exp_now;
  logic [RESP_LAT-1:0] vld_q;
  logic [RESP_LAT-1:0] exp_q;
  logic [CNT_W-1:0]    mis_q;

`ifdef GOSSAMER_LFSR_EN
  assign init_pat = 4'b0001;
  assign gen_d    = {gen_q[2:0], gen_q[3] ^ gen_q[2]};
`else
  assign init_pat = 4'd0;
  assign gen_d    = gen_q + 4'd1;
`endif

  // stop ends the run with the pattern already on the bus this cycle
  assign last_pat = (idx_q == 8'(NUM_PATTERNS - 1)) || stop;

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q  <= IDLE;
      gen_q    <= 4'd0;
      bundle_q <= 4'd0;
      drain_q  <= 3'd0;
      idx_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= DRIVE;
            gen_q    <= init_pat;
            bundle_q <= init_pat;
            idx_q    <= 8'd0;
            busy_q   <= 1'b1;
          end
        end
        DRIVE: begin
          idx_q <= idx_q + 8'd1;
          if (last_pat) begin
            state_q  <= DRAIN;
            bundle_q <= 4'd0;
            drain_q  <= 3'(RESP_LAT - 1);
          end else begin
            gen_q    <= gen_d;
            bundle_q <= gen_d;
          end
        end
        DRAIN: begin
          if (drain_q == 3'd0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exp_now = (|bundle_q[3:2]) & (|bundle_q[1:0]);

  // Expected-response pipeline; valid marks cycles that carried a real pattern
  always_ff @(posedge clk) begin
    if (resetb) begin
      vld_q <= '0;
      exp_q <= '0;
    end else begin
      vld_q[0] <= (state_q == DRIVE);
      exp_q[0] <= exp_now;
      for (int i = 1; i < RESP_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      mis_q <= '0;
    end else if (state_q == IDLE && start) begin
      mis_q <= '0;
    end else if (vld_q[RESP_LAT-1] && (nothing_of_note != exp_q[RESP_LAT-1])
                 && (mis_q != '1)) begin
      mis_q <= mis_q + 1'b1;
    end
  end

  assign gossamer       = bundle_q[3:2];
  assign disconnection  = bundle_q[1];
  assign two_guitars    = bundle_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_count = mis_q;
  assign pattern_idx    = idx_q;

endmodule

// File: doc/gossamer_stimulus.md
Name: gossamer_stimulus

Overview:
Stimulus and checker for the guitarist interface. Drives the gossamer/disconnection/two_guitars bundle with a deterministic pattern sequence. Samples the returned nothing_of_note and scores each response against the reference function: (|gossamer) && (disconnection | two_guitars). Sits opposite the consumer of that bundle: it drives what the consumer samples and samples what the consumer drives.

Parameters:
NUM_PATTERNS, 16, patterns driven per run (1..256)
RESP_LAT, 1, cycles from pattern drive to valid nothing_of_note (1..8)
CNT_W, 8, width of mismatch_count

Ports:
clk  input  1  clock, all logic on rising edge
resetb  input  1  synchronous reset, active-high
start  input  1  begin a run; honoured only in IDLE
stop  input  1  abort pattern issue; honoured only in DRIVE
gossamer  output  2  pattern bits [3:2]
disconnection  output  1  pattern bit [1]
two_guitars  output  1  pattern bit [0]
nothing_of_note  input  1  response from the consumer
busy  output  1  high in DRIVE and DRAIN
done  output  1  one-cycle pulse at end of run
mismatch_count  output  CNT_W  responses differing from expected; saturating
pattern_idx  output  8  index of the pattern currently driven

Behaviour:
- Reset: all outputs 0, FSM=IDLE, pattern generator and expected pipeline cleared. Reset mid-run aborts with no done pulse.
- All outputs are registered.
- FSM states:
  - IDLE: bundle driven 0. start -> DRIVE. On that edge, clear mismatch_count and pattern_idx; pattern = initial value.
  - DRIVE: each cycle drives one pattern and pattern_idx increments. After the pattern with idx NUM_PATTERNS-1 -> DRAIN. If stop is asserted, the current cycle is the last pattern driven -> DRAIN.
  - DRAIN: bundle driven 0 for RESP_LAT cycles while the final responses are checked -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Timing: start sampled at edge N. Pattern k is visible during cycle N+1+k. With a full run, done is high in cycle N+NUM_PATTERNS+RESP_LAT+1.
- Pattern source: 4-bit counter starting at 0, wraps modulo 16. Mapping is {gossamer, disconnection, two_guitars} = pat[3:0].
- Checking:
  - expected = (|pat[3:2]) && (pat[1] | pat[0]), computed per driven pattern.
  - Delayed RESP_LAT cycles with a valid bit.
  - When the delayed valid is 1, nothing_of_note is compared against it; a difference increments mismatch_count.
  - mismatch_count saturates at all-ones.
  - Only driven patterns are scored; IDLE/DRAIN zeros are never scored.
- Boundary conditions:
  - start outside IDLE: ignored.
  - stop outside DRIVE: ignored.
  - stop and start together in IDLE: start wins.
  - stop on the final pattern cycle: same as a normal end.
  - NUM_PATTERNS > 16: pattern wraps, pattern_idx keeps counting.
  - mismatch_count and pattern_idx hold their values after done until the next start.

Optional Feature:
GOSSAMER_LFSR_EN
- Defined: pattern comes from a 4-bit Fibonacci LFSR, x^4+x^3+1, seeded 4'b0001 on start. It steps once per DRIVE cycle (period 15, never 0).
- Undefined: binary counter as above.
- Checking, timing and ports are identical in both builds.

Test Plan:
1. Counter build, defaults, responder modelled as registered reference function, start pulse at edge N -> patterns 0..15 in cycles N+1..N+16, done in cycle N+18, mismatch_count=0, pattern_idx=16.
2. Defaults, nothing_of_note tied 0 -> mismatch_count=9 (9 of 16 patterns expect 1). Tied 1 -> mismatch_count=7.
3. Defaults, tied 1, stop asserted in cycle N+4 -> 4 patterns driven (0..3, all expect 0), DRAIN 1 cycle, done in cycle N+6, mismatch_count=4.
4. CNT_W=2, tied 1 -> mismatch_count saturates at 3. start held high during busy -> no restart; second run starts only after IDLE.
5. resetb asserted in cycle N+8 of DRIVE -> next cycle all outputs 0, no done pulse. New start runs cleanly with mismatch_count=0 against the correct responder.
6. GOSSAMER_LFSR_EN defined, NUM_PATTERNS=15, RESP_LAT=3, correct responder delayed 3 cycles -> pattern sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8; done in cycle N+19; mismatch_count=0.
